// File: rtl/ascensor_pkg.sv
// rtl/ascensor_pkg.sv - shared types, encodings and request decode for the elevator cabin
//
// Contents:
//   estado_t      cabin sequencer states
//   PARADO/SUBE/BAJA  accion encodings
//   NUM_PISOS     number of floors served
//   peticion_t    decoded request {valido, piso}
//   cod_a_piso()  request code -> floor decode, also used by the request memory
package ascensor_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_MOVE_UP    = 3'd1,
    S_MOVE_DN    = 3'd2,
    S_ARRIVE     = 3'd3,
    S_DOOR_OPEN  = 3'd4,
    S_DOOR_CLOSE = 3'd5
  } estado_t;

  localparam logic [1:0] PARADO = 2'd0;
  localparam logic [1:0] SUBE   = 2'd1;
  localparam logic [1:0] BAJA   = 2'd2;

  localparam int         NUM_PISOS = 4;
  localparam logic [1:0] PISO_MAX  = 2'(NUM_PISOS - 1);

  typedef struct packed {
    logic       valido;
    logic [1:0] piso;
  } peticion_t;

  // Cabin calls (1..4) and hall calls (5..10) share floor targets;
  // 0 means no request and 11..15 are unused codes.
  function automatic peticion_t cod_a_piso(input logic [3:0] code);
    peticion_t r;
    case (code)
      4'd1, 4'd5:        r = '{valido: 1'b1, piso: 2'd0};
      4'd2, 4'd6, 4'd7:  r = '{valido: 1'b1, piso: 2'd1};
      4'd3, 4'd8, 4'd9:  r = '{valido: 1'b1, piso: 2'd2};
      4'd4, 4'd10:       r = '{valido: 1'b1, piso: 2'd3};
      default:           r = '{valido: 1'b0, piso: 2'd0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/control_ascensor_temporizador.sv
// rtl/control_ascensor_temporizador.sv - loadable down-counter timing travel and door dwell
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous reset, active-low (count cleared to 0)
//   i_load   in   load i_valor (has priority over counting)
//   i_valor  in   TW-bit load value
//   i_en     in   count enable; the count stops at 0
//   o_fin    out  expiry: count==1, so a load of N gives exactly N cycles
module temporizador #(
  parameter int TW = 28
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [TW-1:0] i_valor,
  input  logic          i_en,
  output logic          o_fin
);

  logic [TW-1:0] r_cuenta;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cuenta <= '0;
    end else if (i_load) begin
      r_cuenta <= i_valor;
    end else if (i_en && (r_cuenta != '0)) begin
      r_cuenta <= r_cuenta - 1'b1;
    end
  end

  assign o_fin = (r_cuenta == TW'(1));

endmodule

// File: rtl/control_ascensor.sv
// rtl/control_ascensor.sv - cabin motion/door sequencer for the 4-floor elevator
//
// Optional feature: define ASCENSOR_PARO_EN to add the `paro` emergency-stop input.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous reset, active-low
//   paro         in   emergency stop (only with ASCENSOR_PARO_EN): freezes the sequencer
//   memoria      in   [3:0] next request code from the request memory (0 = none)
//   boton_abrir  in   door-open button, reloads the dwell time while doors are open
//   accion       out  [1:0] PARADO / SUBE / BAJA
//   piso         out  [1:0] current floor
//   puertas      out  doors open
//   consulta     out  1-cycle strobe asking the memory to refresh memoria
//   destino      out  [1:0] latched target floor
module control_ascensor #(
  parameter int TRAVEL_CYCLES = 100_000_000,
  parameter int DOOR_CYCLES   = 150_000_000,
  parameter int TW            = 28
) (
  input  logic       clk,
  input  logic       rst,
`ifdef ASCENSOR_PARO_EN
  input  logic       paro,
`endif
  input  logic [3:0] memoria,
  input  logic       boton_abrir,
  output logic [1:0] accion,
  output logic [1:0] piso,
  output logic       puertas,
  output logic       consulta,
  output logic [1:0] destino
);

  import ascensor_pkg::*;

  localparam logic [TW-1:0] C_VIAJE  = TW'(TRAVEL_CYCLES);
  localparam logic [TW-1:0] C_PUERTA = TW'(DOOR_CYCLES);

  estado_t       r_estado;
  logic [1:0]    r_piso;
  logic [1:0]    r_destino;
  logic [1:0]    r_accion;
  logic          r_puertas;
  logic          r_consulta;

  estado_t       w_estado_sig;
  logic [1:0]    w_piso_sig;
  logic [1:0]    w_destino_sig;
  logic [1:0]    w_accion_sig;
  logic          w_carga;
  logic [TW-1:0] w_valor;
  logic          w_fin;
  logic          w_run;
  peticion_t     w_pet;

`ifdef ASCENSOR_PARO_EN
  assign w_run = ~paro;
`else
  assign w_run = 1'b1;
`endif

  // Direction to resume toward destino. Hitting a limit floor can only mean
  // a corrupted destino, so the cabin opens its doors there instead.
  function automatic estado_t reanudar(input logic [1:0] p, input logic [1:0] d);
    if (d > p) return (p == PISO_MAX) ? S_DOOR_OPEN : S_MOVE_UP;
    else       return (p == 2'd0)     ? S_DOOR_OPEN : S_MOVE_DN;
  endfunction

  temporizador #(.TW(TW)) u_temporizador (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_carga),
    .i_valor (w_valor),
    .i_en    (w_run),
    .o_fin   (w_fin)
  );

  always_comb begin
    w_pet         = cod_a_piso(memoria);
    w_estado_sig  = r_estado;
    w_piso_sig    = r_piso;
    w_destino_sig = r_destino;
    w_carga       = 1'b0;
    w_valor       = C_VIAJE;
    w_accion_sig  = PARADO;

    case (r_estado)
      S_IDLE: begin
        if (w_pet.valido) begin
          w_destino_sig = w_pet.piso;
          w_carga       = 1'b1;
          if (w_pet.piso > r_piso) begin
            w_estado_sig = S_MOVE_UP;
          end else if (w_pet.piso < r_piso) begin
            w_estado_sig = S_MOVE_DN;
          end else begin
            w_estado_sig = S_DOOR_OPEN;
            w_valor      = C_PUERTA;
          end
        end
      end
      S_MOVE_UP: begin
        if (w_fin) begin
          w_estado_sig = S_ARRIVE;
          if (r_piso != PISO_MAX) w_piso_sig = r_piso + 2'd1;
        end
      end
      S_MOVE_DN: begin
        if (w_fin) begin
          w_estado_sig = S_ARRIVE;
          if (r_piso != 2'd0) w_piso_sig = r_piso - 2'd1;
        end
      end
      S_ARRIVE: begin
        w_carga = 1'b1;
        // A request for the floor just reached makes an intermediate stop
        // without disturbing the final destination.
        if ((r_piso == r_destino) || (w_pet.valido && (w_pet.piso == r_piso))) begin
          w_estado_sig = S_DOOR_OPEN;
          w_valor      = C_PUERTA;
        end else begin
          w_estado_sig = reanudar(r_piso, r_destino);
          if (w_estado_sig == S_DOOR_OPEN) begin
            w_valor       = C_PUERTA;
            w_destino_sig = r_piso;
          end
        end
      end
      S_DOOR_OPEN: begin
        // Button beats expiry on the same cycle.
        if (boton_abrir) begin
          w_carga = 1'b1;
          w_valor = C_PUERTA;
        end else if (w_fin) begin
          w_estado_sig = S_DOOR_CLOSE;
        end
      end
      S_DOOR_CLOSE: begin
        if (r_piso == r_destino) begin
          w_estado_sig = S_IDLE;
        end else begin
          w_carga      = 1'b1;
          w_estado_sig = reanudar(r_piso, r_destino);
          if (w_estado_sig == S_DOOR_OPEN) begin
            w_valor       = C_PUERTA;
            w_destino_sig = r_piso;
          end
        end
      end
      default: w_estado_sig = S_IDLE;
    endcase

    if (!w_run) begin
      w_estado_sig  = r_estado;
      w_piso_sig    = r_piso;
      w_destino_sig = r_destino;
      w_carga       = 1'b0;
    end

    case (w_estado_sig)
      S_MOVE_UP: w_accion_sig = SUBE;
      S_MOVE_DN: w_accion_sig = BAJA;
      default:   w_accion_sig = PARADO;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_estado   <= S_IDLE;
      r_piso     <= 2'd0;
      r_destino  <= 2'd0;
      r_accion   <= PARADO;
      r_puertas  <= 1'b0;
      r_consulta <= 1'b0;
    end else begin
      r_estado   <= w_estado_sig;
      r_piso     <= w_piso_sig;
      r_destino  <= w_destino_sig;
      r_accion   <= w_run ? w_accion_sig : PARADO;
      r_puertas  <= w_run && (w_estado_sig == S_DOOR_OPEN);
      r_consulta <= w_run && ((w_estado_sig == S_ARRIVE) || (w_estado_sig == S_DOOR_CLOSE));
    end
  end

  assign accion   = r_accion;
  assign piso     = r_piso;
  assign puertas  = r_puertas;
  assign consulta = r_consulta;
  assign destino  = r_destino;

endmodule

// File: tb/tb_control_ascensor.sv
// tb/tb_control_ascensor.sv - scoreboard bench for control_ascensor (TRAVEL_CYCLES=4, DOOR_CYCLES=3)
module tb_control_ascensor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       boton_abrir = 1'b0;
  logic [3:0] memoria = 4'd0;
`ifdef ASCENSOR_PARO_EN
  logic       paro = 1'b0;
`endif
  logic [1:0] accion;
  logic [1:0] piso;
  logic       puertas;
  logic       consulta;
  logic [1:0] destino;

  control_ascensor #(
    .TRAVEL_CYCLES (4),
    .DOOR_CYCLES   (3),
    .TW            (28)
  ) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef ASCENSOR_PARO_EN
    .paro        (paro),
`endif
    .memoria     (memoria),
    .boton_abrir (boton_abrir),
    .accion      (accion),
    .piso        (piso),
    .puertas     (puertas),
    .consulta    (consulta),
    .destino     (destino)
  );

  typedef struct {
    int         cyc;
    logic [7:0] v;
    string      tag;
  } esp_t;

  esp_t  sb[$];
  int    cyc   = 0;
  int    nxt   = 1;
  int    n_chk = 0;
  int    n_ok  = 0;
  string tag   = "reset";

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: each cycle the DUT presents one output vector; pop the
  // expectation stamped for this cycle and compare.
  always @(negedge clk) begin
    esp_t       e;
    logic [7:0] got;
    got = {accion, piso, puertas, consulta, destino};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_chk++;
      if (e.cyc == cyc && got === e.v)
        n_ok++;
      else
        $display("FAIL %s cyc=%0d (due %0d): got acc=%0d piso=%0d pu=%0d co=%0d de=%0d, expected acc=%0d piso=%0d pu=%0d co=%0d de=%0d",
                 e.tag, cyc, e.cyc, got[7:6], got[5:4], got[3], got[2], got[1:0],
                 e.v[7:6], e.v[5:4], e.v[3], e.v[2], e.v[1:0]);
    end
  end

  // Push n expected vectors for the next n cycles, then let them elapse.
  // Inputs set before a call are sampled by the edge that starts its first cycle.
  task automatic step(input int n, input logic [1:0] a, input logic [1:0] p,
                      input logic pu, input logic co, input logic [1:0] de);
    esp_t e;
    for (int i = 0; i < n; i++) begin
      e.cyc = nxt;
      e.v   = {a, p, pu, co, de};
      e.tag = tag;
      sb.push_back(e);
      nxt++;
    end
    repeat (n) @(negedge clk);
  endtask

  initial begin
    step(2, 0, 0, 0, 0, 0);

    tag = "reset_mid_move";
    rst = 1'b1; memoria = 4'd2;
    step(1, 1, 0, 0, 0, 1);
    memoria = 4'd0;
    step(1, 1, 0, 0, 0, 1);
    rst = 1'b0;
    step(2, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step(2, 0, 0, 0, 0, 0);

    tag = "up_0_to_3";
    memoria = 4'd4;
    step(1, 1, 0, 0, 0, 3);
    memoria = 4'd0;
    step(3, 1, 0, 0, 0, 3);
    step(1, 0, 1, 0, 1, 3);
    step(4, 1, 1, 0, 0, 3);
    step(1, 0, 2, 0, 1, 3);
    step(4, 1, 2, 0, 0, 3);
    step(1, 0, 3, 0, 1, 3);
    step(3, 0, 3, 1, 0, 3);
    step(1, 0, 3, 0, 1, 3);
    step(2, 0, 3, 0, 0, 3);

    tag = "down_3_to_0";
    memoria = 4'd1;
    step(1, 2, 3, 0, 0, 0);
    memoria = 4'd0;
    step(3, 2, 3, 0, 0, 0);
    step(1, 0, 2, 0, 1, 0);
    step(4, 2, 2, 0, 0, 0);
    step(1, 0, 1, 0, 1, 0);
    step(4, 2, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    step(3, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);

    tag = "intermediate_stop";
    memoria = 4'd4;
    step(1, 1, 0, 0, 0, 3);
    memoria = 4'd0;
    step(3, 1, 0, 0, 0, 3);
    memoria = 4'd6;
    step(1, 0, 1, 0, 1, 3);
    step(1, 0, 1, 1, 0, 3);
    memoria = 4'd0;
    step(2, 0, 1, 1, 0, 3);
    step(1, 0, 1, 0, 1, 3);
    step(4, 1, 1, 0, 0, 3);
    step(1, 0, 2, 0, 1, 3);
    step(4, 1, 2, 0, 0, 3);
    step(1, 0, 3, 0, 1, 3);
    step(3, 0, 3, 1, 0, 3);
    step(1, 0, 3, 0, 1, 3);
    step(1, 0, 3, 0, 0, 3);

    tag = "boton_on_expiry";
    memoria = 4'd10;
    step(1, 0, 3, 1, 0, 3);
    memoria = 4'd0;
    step(2, 0, 3, 1, 0, 3);
    boton_abrir = 1'b1;
    step(1, 0, 3, 1, 0, 3);
    boton_abrir = 1'b0;
    step(2, 0, 3, 1, 0, 3);
    step(1, 0, 3, 0, 1, 3);
    step(1, 0, 3, 0, 0, 3);

    tag = "down_3_to_2";
    memoria = 4'd3;
    step(1, 2, 3, 0, 0, 2);
    memoria = 4'd0;
    step(3, 2, 3, 0, 0, 2);
    step(1, 0, 2, 0, 1, 2);
    step(3, 0, 2, 1, 0, 2);
    step(1, 0, 2, 0, 1, 2);
    step(1, 0, 2, 0, 0, 2);

    tag = "same_floor_open";
    memoria = 4'd8;
    step(1, 0, 2, 1, 0, 2);
    memoria = 4'd0;
    step(2, 0, 2, 1, 0, 2);
    step(1, 0, 2, 0, 1, 2);
    step(1, 0, 2, 0, 0, 2);

    tag = "invalid_codes_idle";
    step(3, 0, 2, 0, 0, 2);
    memoria = 4'd12;
    step(3, 0, 2, 0, 0, 2);
    memoria = 4'd15;
    step(2, 0, 2, 0, 0, 2);
    memoria = 4'd0;
    step(1, 0, 2, 0, 0, 2);

`ifdef ASCENSOR_PARO_EN
    tag = "paro_mid_travel";
    memoria = 4'd4;
    step(1, 1, 2, 0, 0, 3);
    memoria = 4'd0;
    step(1, 1, 2, 0, 0, 3);
    paro = 1'b1;
    step(5, 0, 2, 0, 0, 3);
    paro = 1'b0;
    step(2, 1, 2, 0, 0, 3);
    step(1, 0, 3, 0, 1, 3);
    step(3, 0, 3, 1, 0, 3);
    step(1, 0, 3, 0, 1, 3);
    step(1, 0, 3, 0, 0, 3);
`endif

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
